// File: rtl/ps_defs.sv
// Shared program-sequencer definitions: PM bus widths (shared with memory),
// the reset fetch address, and the redirect-source encoding used by ps_fetch.
package ps_defs;

  localparam int PM_ADDR_W = 16;
  localparam int PM_DATA_W = 32;
  localparam int RESET_PC  = 0;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_JMP  = 2'd1,
    REDIR_RTS  = 2'd2
  } redir_e;

  // A jump always wins over a return; a return with a jump is not popped.
  function automatic redir_e redir_sel(input logic jmp, input logic rts);
    if (jmp)      return REDIR_JMP;
    else if (rts) return REDIR_RTS;
    else          return REDIR_NONE;
  endfunction

endpackage

// File: rtl/ps_pc_stack.sv
// Hardware PC stack for call/return: LIFO of DEPTH x WIDTH return addresses.
// Push on full and pop on empty are ignored here; the caller flags them.
module ps_pc_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_cnt;
  logic [PW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  // Occupancy carries one extra bit so a full stack is distinguishable from empty.
  assign w_wr_idx  = r_cnt[PW-1:0];
  assign w_top_idx = w_wr_idx - PW'(1);
  assign o_full    = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_top     = r_mem[w_top_idx];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_do_push) begin
      r_cnt <= r_cnt + (PW+1)'(1);
    end else if (w_do_pop) begin
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/ps_fetch.sv
// Program-sequencer fetch stage: drives the PM read port, captures the returned
// word into the IR, handles stall and jump/call/return redirects. The PC stack
// and its sticky flags exist only when PS_PCSTACK_EN is defined.
module ps_fetch
  import ps_defs::*;
#(
  parameter int PMA_SIZE  = PM_ADDR_W,
  parameter int PMD_SIZE  = PM_DATA_W,
  parameter int STK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_stall,
  input  logic                ps_jmp,
  input  logic [PMA_SIZE-1:0] ps_jmp_add,
  input  logic                ps_call,
  input  logic                ps_rts,
  input  logic [PMD_SIZE-1:0] pm_ps_op,
  output logic                ps_pm_cslt,
  output logic                ps_pm_wrb,
  output logic [PMA_SIZE-1:0] ps_pm_add,
  output logic [PMD_SIZE-1:0] ps_ir,
  output logic                ps_ir_vld,
  output logic [PMA_SIZE-1:0] ps_ir_pc,
  output logic                ps_stk_ovf,
  output logic                ps_stk_unf
);

  logic                r_run;
  logic [PMA_SIZE-1:0] r_pc;
  logic                r_pend_vld;
  logic [PMA_SIZE-1:0] r_pend_pc;
  logic [PMD_SIZE-1:0] r_ir;
  logic                r_ir_vld;
  logic [PMA_SIZE-1:0] r_ir_pc;

  logic                w_cslt;
  redir_e              w_redir;
  logic [PMA_SIZE-1:0] w_target;
  logic                w_stk_empty;
  logic [PMA_SIZE-1:0] w_stk_top;

  assign w_cslt = r_run & ~ps_stall;

`ifdef PS_PCSTACK_EN
  logic                w_stk_full;
  logic                w_push;
  logic                w_pop;
  logic [PMA_SIZE-1:0] w_ret_pc;
  logic                r_ovf;
  logic                r_unf;

  assign w_redir  = redir_sel(ps_jmp, ps_rts);
  assign w_ret_pc = r_ir_pc + PMA_SIZE'(1);
  assign w_push   = ps_jmp && ps_call;
  assign w_pop    = (w_redir == REDIR_RTS);

  ps_pc_stack #(
    .DEPTH (STK_DEPTH),
    .WIDTH (PMA_SIZE)
  ) u_pc_stack (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_ret_pc),
    .o_top   (w_stk_top),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  // Overflow/underflow are sticky until reset so software can poll them late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push && w_stk_full) r_ovf <= 1'b1;
      if (w_pop && w_stk_empty) r_unf <= 1'b1;
    end
  end

  assign ps_stk_ovf = r_ovf;
  assign ps_stk_unf = r_unf;
`else
  logic w_unused_cfg;

  assign w_redir      = redir_sel(ps_jmp, 1'b0);
  assign w_stk_empty  = 1'b1;
  assign w_stk_top    = '0;
  assign ps_stk_ovf   = 1'b0;
  assign ps_stk_unf   = 1'b0;
  assign w_unused_cfg = ^{ps_call, ps_rts, (STK_DEPTH != 0)};
`endif

  // Return on an empty stack restarts from address 0.
  always_comb begin
    w_target = r_pc + PMA_SIZE'(1);
    unique case (w_redir)
      REDIR_JMP: w_target = ps_jmp_add;
      REDIR_RTS: w_target = w_stk_empty ? '0 : w_stk_top;
      default:   ;
    endcase
  end

  // A redirect flushes both the word in flight and the IR valid, even in stall;
  // IR contents stay so a later call still sees the last fetched address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run      <= 1'b0;
      r_pc       <= PMA_SIZE'(RESET_PC);
      r_pend_vld <= 1'b0;
      r_pend_pc  <= '0;
      r_ir       <= '0;
      r_ir_vld   <= 1'b0;
      r_ir_pc    <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_redir != REDIR_NONE) begin
        r_pc       <= w_target;
        r_pend_vld <= 1'b0;
        r_ir_vld   <= 1'b0;
      end else if (w_cslt) begin
        r_pc       <= w_target;
        r_pend_vld <= 1'b1;
        r_pend_pc  <= r_pc;
        if (r_pend_vld) begin
          r_ir     <= pm_ps_op;
          r_ir_pc  <= r_pend_pc;
          r_ir_vld <= 1'b1;
        end
      end
    end
  end

  assign ps_pm_cslt = w_cslt;
  assign ps_pm_wrb  = 1'b0;
  assign ps_pm_add  = r_pc;
  assign ps_ir      = r_ir;
  assign ps_ir_vld  = r_ir_vld;
  assign ps_ir_pc   = r_ir_pc;

endmodule

// File: tb/tb_ps_fetch.sv
// Bench for ps_fetch: directed scenarios plus a randomized run checked against
// a program-flow model (next-address rule, LIFO of return addresses).
`timescale 1ns/1ps
module tb_ps_fetch;

  localparam int PMA   = 16;
  localparam int PMD   = 32;
  localparam int DEPTH = 4;
`ifdef PS_PCSTACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic           clk        = 1'b0;
  logic           reset      = 1'b0;
  logic           ps_stall   = 1'b0;
  logic           ps_jmp     = 1'b0;
  logic [PMA-1:0] ps_jmp_add = '0;
  logic           ps_call    = 1'b0;
  logic           ps_rts     = 1'b0;
  logic [PMD-1:0] pm_ps_op   = '0;
  logic           ps_pm_cslt;
  logic           ps_pm_wrb;
  logic [PMA-1:0] ps_pm_add;
  logic [PMD-1:0] ps_ir;
  logic           ps_ir_vld;
  logic [PMA-1:0] ps_ir_pc;
  logic           ps_stk_ovf;
  logic           ps_stk_unf;

  logic [PMD-1:0] mem [0:65535];
  int n_run  = 0;
  int n_fail = 0;

  ps_fetch #(.PMA_SIZE(PMA), .PMD_SIZE(PMD), .STK_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps_stall   (ps_stall),
    .ps_jmp     (ps_jmp),
    .ps_jmp_add (ps_jmp_add),
    .ps_call    (ps_call),
    .ps_rts     (ps_rts),
    .pm_ps_op   (pm_ps_op),
    .ps_pm_cslt (ps_pm_cslt),
    .ps_pm_wrb  (ps_pm_wrb),
    .ps_pm_add  (ps_pm_add),
    .ps_ir      (ps_ir),
    .ps_ir_vld  (ps_ir_vld),
    .ps_ir_pc   (ps_ir_pc),
    .ps_stk_ovf (ps_stk_ovf),
    .ps_stk_unf (ps_stk_unf)
  );

  always #5 clk = ~clk;

  // Program memory: registered read, output held while chip select is low.
  always @(posedge clk) begin
    if (ps_pm_cslt) pm_ps_op <= mem[ps_pm_add];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_run++; if (ps_pm_add !== 16'h0000) begin n_fail++; $display("FAIL reset_add: got %h want 0000", ps_pm_add); end
    n_run++; if (ps_pm_cslt !== 1'b0) begin n_fail++; $display("FAIL reset_cslt: got %b want 0", ps_pm_cslt); end
    n_run++; if (ps_pm_wrb !== 1'b0) begin n_fail++; $display("FAIL reset_wrb: got %b want 0", ps_pm_wrb); end
    n_run++; if (ps_ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", ps_ir); end
    n_run++; if (ps_ir_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", ps_ir_vld); end
    n_run++; if (ps_ir_pc !== 16'h0) begin n_fail++; $display("FAIL reset_irpc: got %h want 0", ps_ir_pc); end
    n_run++; if ({ps_stk_ovf, ps_stk_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {ps_stk_ovf, ps_stk_unf}); end
  endtask

  task automatic test_sequential();
    int exp_ir [4];
    exp_ir[0] = 11; exp_ir[1] = 22; exp_ir[2] = 33; exp_ir[3] = 44;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_run++; if (ps_pm_cslt !== 1'b0) begin n_fail++; $display("FAIL seq_cslt0: got %b want 0", ps_pm_cslt); end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_run++; if (ps_pm_cslt !== 1'b1) begin n_fail++; $display("FAIL seq_cslt c%0d: got %b want 1", c, ps_pm_cslt); end
      n_run++; if (ps_pm_add !== 16'(c - 1)) begin n_fail++; $display("FAIL seq_add c%0d: got %h want %h", c, ps_pm_add, 16'(c - 1)); end
      n_run++; if (ps_ir_vld !== (c >= 3)) begin n_fail++; $display("FAIL seq_vld c%0d: got %b want %b", c, ps_ir_vld, (c >= 3)); end
      if (c >= 3) begin
        n_run++; if (ps_ir !== 32'(exp_ir[c-3])) begin n_fail++; $display("FAIL seq_ir c%0d: got %0d want %0d", c, ps_ir, exp_ir[c-3]); end
        n_run++; if (ps_ir_pc !== 16'(c - 3)) begin n_fail++; $display("FAIL seq_irpc c%0d: got %h want %h", c, ps_ir_pc, 16'(c - 3)); end
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    n_run++; if (ps_pm_add !== 16'h0006) begin n_fail++; $display("FAIL stall_pre_add: got %h want 0006", ps_pm_add); end
    ps_stall = 1'b1;
    #1;
    n_run++; if (ps_pm_cslt !== 1'b0) begin n_fail++; $display("FAIL stall_cslt: got %b want 0", ps_pm_cslt); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_run++; if (ps_pm_add !== 16'h0006) begin n_fail++; $display("FAIL stall_add k%0d: got %h want 0006", k, ps_pm_add); end
      n_run++; if (ps_ir_pc !== 16'h0004 || ps_ir !== mem[4] || ps_ir_vld !== 1'b1) begin
        n_fail++; $display("FAIL stall_ir k%0d: got pc %h ir %h vld %b want pc 0004 ir %h vld 1", k, ps_ir_pc, ps_ir, ps_ir_vld, mem[4]);
      end
    end
    ps_stall = 1'b0;
    for (int a = 5; a <= 7; a++) begin
      @(negedge clk);
      n_run++; if (ps_ir_pc !== 16'(a) || ps_ir !== mem[a] || ps_ir_vld !== 1'b1) begin
        n_fail++; $display("FAIL stall_resume a%0d: got pc %h ir %h vld %b", a, ps_ir_pc, ps_ir, ps_ir_vld);
      end
    end
  endtask

  task automatic test_jump();
    ps_jmp = 1'b1; ps_jmp_add = 16'h0020;
    @(negedge clk);
    ps_jmp = 1'b0;
    n_run++; if (ps_ir_vld !== 1'b0 || ps_pm_add !== 16'h0020) begin n_fail++; $display("FAIL jmp_b1: got vld %b add %h want 0 0020", ps_ir_vld, ps_pm_add); end
    @(negedge clk);
    n_run++; if (ps_ir_vld !== 1'b0) begin n_fail++; $display("FAIL jmp_b2: got vld %b want 0", ps_ir_vld); end
    for (int a = 32'h20; a <= 32'h21; a++) begin
      @(negedge clk);
      n_run++; if (ps_ir_pc !== 16'(a) || ps_ir !== mem[a] || ps_ir_vld !== 1'b1) begin
        n_fail++; $display("FAIL jmp_tgt %h: got pc %h vld %b", a, ps_ir_pc, ps_ir_vld);
      end
    end
  endtask

  task automatic test_call_rts();
    ps_jmp = 1'b1; ps_jmp_add = 16'h0010;
    @(negedge clk); ps_jmp = 1'b0;
    repeat (2) @(negedge clk);
    n_run++; if (ps_ir_pc !== 16'h0010 || ps_ir_vld !== 1'b1) begin n_fail++; $display("FAIL call_src: got pc %h vld %b want 0010 1", ps_ir_pc, ps_ir_vld); end
    ps_jmp = 1'b1; ps_call = 1'b1; ps_jmp_add = 16'h0040;
    @(negedge clk); ps_jmp = 1'b0; ps_call = 1'b0;
    repeat (2) @(negedge clk);
    n_run++; if (ps_ir_pc !== 16'h0040) begin n_fail++; $display("FAIL call_tgt0: got %h want 0040", ps_ir_pc); end
    @(negedge clk);
    n_run++; if (ps_ir_pc !== 16'h0041) begin n_fail++; $display("FAIL call_tgt1: got %h want 0041", ps_ir_pc); end
    ps_rts = 1'b1;
    @(negedge clk); ps_rts = 1'b0;
    n_run++; if (ps_pm_add !== (STK_EN ? 16'h0011 : 16'h0044)) begin n_fail++; $display("FAIL rts_add: got %h want %h", ps_pm_add, (STK_EN ? 16'h0011 : 16'h0044)); end
    n_run++; if (ps_ir_vld !== !STK_EN) begin n_fail++; $display("FAIL rts_flush: got %b want %b", ps_ir_vld, !STK_EN); end
    repeat (2) @(negedge clk);
    n_run++; if (ps_ir_pc !== (STK_EN ? 16'h0011 : 16'h0044)) begin n_fail++; $display("FAIL rts_ret: got %h want %h", ps_ir_pc, (STK_EN ? 16'h0011 : 16'h0044)); end
  endtask

  task automatic test_overflow();
    logic [PMA-1:0] exp_add;
    for (int i = 0; i < DEPTH + 1; i++) begin
      ps_jmp = 1'b1; ps_call = 1'b1; ps_jmp_add = 16'(32'h100 + i);
      @(negedge clk);
      n_run++; if (ps_stk_ovf !== (STK_EN && i == DEPTH)) begin n_fail++; $display("FAIL ovf i%0d: got %b want %b", i, ps_stk_ovf, (STK_EN && i == DEPTH)); end
    end
    ps_jmp = 1'b0; ps_call = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      ps_rts = 1'b1;
      @(negedge clk);
      exp_add = STK_EN ? ((i < DEPTH) ? 16'h0012 : 16'h0000) : 16'(32'h105 + i);
      n_run++; if (ps_pm_add !== exp_add) begin n_fail++; $display("FAIL pop_add i%0d: got %h want %h", i, ps_pm_add, exp_add); end
      n_run++; if (ps_stk_unf !== (STK_EN && i == DEPTH)) begin n_fail++; $display("FAIL unf i%0d: got %b want %b", i, ps_stk_unf, (STK_EN && i == DEPTH)); end
      n_run++; if (ps_stk_ovf !== STK_EN) begin n_fail++; $display("FAIL ovf_sticky i%0d: got %b want %b", i, ps_stk_ovf, STK_EN); end
    end
    ps_rts = 1'b0;
  endtask

  task automatic test_wrap_and_priority();
    ps_jmp = 1'b1; ps_jmp_add = 16'hFFFF;
    @(negedge clk); ps_jmp = 1'b0;
    n_run++; if (ps_pm_add !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_a: got %h want ffff", ps_pm_add); end
    @(negedge clk);
    n_run++; if (ps_pm_add !== 16'h0000) begin n_fail++; $display("FAIL wrap_b: got %h want 0000", ps_pm_add); end
    @(negedge clk);
    n_run++; if (ps_ir_pc !== 16'hFFFF || ps_ir !== mem[16'hFFFF]) begin n_fail++; $display("FAIL wrap_ir0: got pc %h ir %h", ps_ir_pc, ps_ir); end
    @(negedge clk);
    n_run++; if (ps_ir_pc !== 16'h0000 || ps_ir !== 32'd11) begin n_fail++; $display("FAIL wrap_ir1: got pc %h ir %0d want 0000 11", ps_ir_pc, ps_ir); end
    ps_jmp = 1'b1; ps_call = 1'b1; ps_jmp_add = 16'h0300;
    @(negedge clk);
    ps_call = 1'b0; ps_rts = 1'b1; ps_jmp_add = 16'h0400;
    @(negedge clk);
    ps_jmp = 1'b0;
    n_run++; if (ps_pm_add !== 16'h0400) begin n_fail++; $display("FAIL jmp_rts_prio: got %h want 0400", ps_pm_add); end
    @(negedge clk);
    ps_rts = 1'b0;
    n_run++; if (ps_pm_add !== (STK_EN ? 16'h0001 : 16'h0401)) begin n_fail++; $display("FAIL depth_kept: got %h want %h", ps_pm_add, (STK_EN ? 16'h0001 : 16'h0401)); end
  endtask

  task automatic test_async_reset();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_run++; if ({ps_pm_add, ps_ir_pc} !== 32'h0 || ps_ir !== 32'h0) begin n_fail++; $display("FAIL async_data: got add %h pc %h ir %h want 0", ps_pm_add, ps_ir_pc, ps_ir); end
    n_run++; if ({ps_pm_cslt, ps_ir_vld, ps_stk_ovf, ps_stk_unf} !== 4'b0) begin n_fail++; $display("FAIL async_ctl: got %b want 0000", {ps_pm_cslt, ps_ir_vld, ps_stk_ovf, ps_stk_unf}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [PMA-1:0] stk [$];
    logic [PMA-1:0] m_next, m_cur;
    bit m_ovf, m_unf, prev_redir, prev_vld, prev_cons, redir;
    m_next = '0; m_cur = '0; m_ovf = 0; m_unf = 0;
    prev_redir = 0; prev_vld = 0; prev_cons = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_redir) begin
        n_run++; if (ps_ir_vld !== 1'b0) begin n_fail++; $display("FAIL rnd_flush cyc%0d: got vld %b want 0", cyc, ps_ir_vld); end
      end else begin
        if (prev_cons) begin
          n_run++; if (ps_ir_vld !== 1'b1) begin n_fail++; $display("FAIL rnd_lost cyc%0d: got vld %b want 1", cyc, ps_ir_vld); end
        end
        if (ps_ir_vld === 1'b1) begin
          if (!prev_vld || prev_cons) begin
            m_cur  = m_next;
            m_next = m_next + 16'd1;
          end
          n_run++; if (ps_ir_pc !== m_cur) begin n_fail++; $display("FAIL rnd_pc cyc%0d: got %h want %h", cyc, ps_ir_pc, m_cur); end
          n_run++; if (ps_ir !== mem[m_cur]) begin n_fail++; $display("FAIL rnd_ir cyc%0d: got %h want %h", cyc, ps_ir, mem[m_cur]); end
        end
      end
      n_run++; if ({ps_stk_ovf, ps_stk_unf} !== {m_ovf, m_unf}) begin n_fail++; $display("FAIL rnd_flags cyc%0d: got %b want %b", cyc, {ps_stk_ovf, ps_stk_unf}, {m_ovf, m_unf}); end

      ps_stall   = ($urandom_range(0, 99) < 25);
      ps_jmp     = ($urandom_range(0, 99) < 7);
      ps_call    = ($urandom_range(0, 99) < 60);
      ps_rts     = ($urandom_range(0, 99) < 5);
      ps_jmp_add = 16'($urandom_range(0, 65535));

      redir = 0;
      if (ps_jmp) begin
        if (STK_EN && ps_call) begin
          if (stk.size() < DEPTH) stk.push_back(m_cur + 16'd1);
          else m_ovf = 1;
        end
        m_next = ps_jmp_add;
        redir  = 1;
      end else if (STK_EN && ps_rts) begin
        if (stk.size() == 0) begin
          m_next = '0;
          m_unf  = 1;
        end else begin
          m_next = stk.pop_back();
        end
        redir = 1;
      end
      prev_cons  = ps_ir_vld && !ps_stall && !redir;
      prev_vld   = ps_ir_vld;
      prev_redir = redir;
      #1;
      n_run++; if (ps_pm_cslt !== !ps_stall) begin n_fail++; $display("FAIL rnd_cslt cyc%0d: got %b want %b", cyc, ps_pm_cslt, !ps_stall); end
    end
    ps_stall = 0; ps_jmp = 0; ps_call = 0; ps_rts = 0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = {16'(a) ^ 16'hC3A5, 16'(a)};
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_call_rts();
    test_overflow();
    test_wrap_and_priority();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
